// File: rtl/noc_pkg.sv
// Shared NoC router types: output-port codes and flit destination layout.
package noc_pkg;

    typedef enum logic [2:0] {
        PORT_NORTH = 3'd0,
        PORT_SOUTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_LOCAL = 3'd4,
        PORT_NONE  = 3'd7
    } port_e;

    localparam int COORD_W = 4;

    // Field offsets measured down from the flit MSB.
    localparam int DEST_X_OFS = 0;
    localparam int DEST_Y_OFS = COORD_W;

endpackage

// File: rtl/noc_xy_route.sv
// Dimension-ordered XY routing decision for one destination.
module noc_xy_route
    import noc_pkg::*;
(
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    input  logic [COORD_W-1:0] my_x,
    input  logic [COORD_W-1:0] my_y,
    output port_e              route
);

    logic x_gt;
    logic x_lt;
    logic y_gt;
    logic y_lt;

    assign x_gt = dest_x > my_x;
    assign x_lt = dest_x < my_x;
    assign y_gt = dest_y > my_y;
    assign y_lt = dest_y < my_y;

    // X is resolved fully before Y; terms are made mutually exclusive.
    always_comb begin
        route = PORT_LOCAL;
        unique case (1'b1)
            x_gt:                 route = PORT_EAST;
            x_lt:                 route = PORT_WEST;
            (!x_gt && !x_lt && y_gt): route = PORT_NORTH;
            (!x_gt && !x_lt && y_lt): route = PORT_SOUTH;
            default:              route = PORT_LOCAL;
        endcase
    end

endmodule

// File: rtl/noc_input_buffer.sv
// Router input-port flit FIFO with head-flit XY route and credit return.
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLIT_W-1:0]        flit_i,
    input  logic                     flit_valid_i,
    input  logic                     read_i,
    output logic [FLIT_W-1:0]        flit_o,
    output logic [2:0]               req_port_addr_o,
    output logic                     credit_en_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              credit_q;
    logic              overflow_q;

    logic              empty;
    logic              full;
    logic              rd_en;
    logic              wr_en;
    logic              drop;
    logic [FLIT_W-1:0] head;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    port_e             head_route;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rd_en = read_i && !empty;
    // A full buffer still accepts a write when the head leaves this cycle.
    assign wr_en = flit_valid_i && (!full || rd_en);
    assign drop  = flit_valid_i && !wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (rd_en && !wr_en)
                count <= count - 1'b1;
            credit_q <= rd_en;
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= flit_i;
    end

    assign head   = mem[rd_ptr];
    assign head_x = head[FLIT_W-1-DEST_X_OFS -: COORD_W];
    assign head_y = head[FLIT_W-1-DEST_Y_OFS -: COORD_W];

    noc_xy_route u_route (
        .dest_x (head_x),
        .dest_y (head_y),
        .my_x   (MY_X_C),
        .my_y   (MY_Y_C),
        .route  (head_route)
    );

    assign flit_o          = head;
    assign req_port_addr_o = empty ? PORT_NONE : head_route;
    assign credit_en_o     = credit_q;
    assign count_o         = count;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Scoreboard bench for noc_input_buffer with a queue-based reference FIFO.
module tb_noc_input_buffer;

    localparam int FLIT_W = 32;
    localparam int DEPTH  = 4;
    localparam int MY_X   = 1;
    localparam int MY_Y   = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FLIT_W-1:0] flit_i = '0;
    logic              flit_valid_i = 1'b0;
    logic              read_i = 1'b0;
    logic [FLIT_W-1:0] flit_o;
    logic [2:0]        req_port_addr_o;
    logic              credit_en_o;
    logic [2:0]        count_o;
    logic              overflow_o;

    noc_input_buffer #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .MY_X   (MY_X),
        .MY_Y   (MY_Y)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flit_i          (flit_i),
        .flit_valid_i    (flit_valid_i),
        .read_i          (read_i),
        .flit_o          (flit_o),
        .req_port_addr_o (req_port_addr_o),
        .credit_en_o     (credit_en_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] flit;
        logic [2:0]  port;
    } exp_t;

    exp_t        exp_q[$];
    logic [2:0]  seq_q[$];
    int          mcount = 0;
    bit          mov = 1'b0;
    bit          mcred = 1'b0;
    int          credits = 0;
    int          tests = 0;
    int          fails = 0;

    int          dxs[5] = '{2, 0, 1, 1, 1};
    int          dys[5] = '{1, 1, 3, 0, 1};
    logic [2:0]  exp_ports[5] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd4};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // XY routing rule written straight from the port-selection table.
    function automatic logic [2:0] ref_route(logic [31:0] f);
        int dx;
        int dy;
        dx = int'(f[31:28]);
        dy = int'(f[27:24]);
        if (dx > MY_X) return 3'd2;
        if (dx < MY_X) return 3'd3;
        if (dy > MY_Y) return 3'd0;
        if (dy < MY_Y) return 3'd1;
        return 3'd4;
    endfunction

    function automatic logic [31:0] mk(int dx, int dy);
        logic [31:0] f;
        f = $urandom;
        f[31:28] = dx[3:0];
        f[27:24] = dy[3:0];
        return f;
    endfunction

    // Reference model: accepts/drops flits and predicts the credit pulse.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            mcount = 0;
            mov = 1'b0;
            mcred = 1'b0;
        end else begin
            bit rd;
            bit wr;
            rd = read_i && (mcount > 0);
            wr = flit_valid_i && ((mcount < DEPTH) || rd);
            if (wr)
                exp_q.push_back('{flit_i, ref_route(flit_i)});
            if (flit_valid_i && !wr)
                mov = 1'b1;
            mcount = mcount + int'(wr) - int'(rd);
            mcred = rd;
        end
    end

    // Monitor: checks the head against the scoreboard and pops on reads.
    initial forever begin
        @(negedge clk);
        chk("count", 32'(count_o), mcount);
        chk("overflow", 32'(overflow_o), 32'(mov));
        chk("credit", 32'(credit_en_o), 32'(mcred));
        if (credit_en_o === 1'b1)
            credits++;
        if (mcount == 0) begin
            chk("port_empty", 32'(req_port_addr_o), 32'd7);
        end else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: empty queue, model count %0d", mcount);
        end else begin
            chk("flit", flit_o, exp_q[0].flit);
            chk("port", 32'(req_port_addr_o), 32'(exp_q[0].port));
            if (rst_n && read_i) begin
                seq_q.push_back(req_port_addr_o);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(bit v, logic [31:0] f, bit r);
        flit_valid_i = v;
        flit_i = f;
        read_i = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0);

        seq_q.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk(dxs[i], dys[i]), 1'b0);
            step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);
        chk("route_seq_len", seq_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < seq_q.size())
                chk($sformatf("route_seq%0d", i), 32'(seq_q[i]), 32'(exp_ports[i]));

        for (int i = 0; i < 4; i++)
            step(1'b1, mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15))), 1'b0);
        step(1'b1, mk(9, 9), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_overflow", 32'(overflow_o), 32'd1);

        step(1'b1, mk(1, 1), 1'b1);
        chk("rw_full_count", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        credits = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk(int'($urandom_range(0, 3)), 2), 1'b0);
            step(1'b1, mk(2, int'($urandom_range(0, 3))), 1'b1);
            step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("wrap_credits", credits, 10);
        chk("wrap_no_ovf", 32'(overflow_o), 32'd0);

        for (int i = 0; i < 3; i++)
            step(1'b1, mk(0, 0), 1'b0);
        step(1'b0, '0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_port", 32'(req_port_addr_o), 32'd7);
        chk("arst_credit", 32'(credit_en_o), 32'd0);
        chk("arst_ovf", 32'(overflow_o), 32'd0);
        flit_valid_i = 1'b0;
        read_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)),
                 mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++)
            step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("drained", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_input_buffer.md
# noc_input_buffer

Per-input-port flit buffer of the NoC router; the receiving end of the credit-based link flow control. It stores flits arriving from the upstream router's output link and computes the XY route of the head flit for the local flow-control unit. It pops the head flit when the crossbar reads it and returns one credit pulse upstream per dequeued flit. The upstream flow-control unit starts with DEPTH credits, so the buffer never overflows under correct operation.

## Interface
- FLIT_W, 32: flit width in bits; destination field in the top 8 bits.
- DEPTH, 4: buffer entries, equal to the upstream credit count; power of 2, ≥2.
- MY_X, 0: this router's X coordinate (4 bits).
- MY_Y, 0: this router's Y coordinate (4 bits).

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  router clock.
- rst_n  in  1  asynchronous active-low reset.
- flit_i  in  FLIT_W  incoming flit from upstream link.
- flit_valid_i  in  1  flit_i is valid this cycle; upstream asserts it only while holding a credit.
- read_i  in  1  crossbar dequeues the head flit this cycle.
- flit_o  out  FLIT_W  head flit; don't-care when empty.
- req_port_addr_o  out  3  XY output-port request for the head flit; PORT_NONE when empty.
- credit_en_o  out  1  one-cycle credit-return pulse to upstream.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky error: flit dropped because buffer was full.

## Operation
- Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally at DEPTH.
- Occupancy count ranges 0..DEPTH.
- Write is accepted when flit_valid_i && (count<DEPTH || read accepted this cycle). Flit is stored at wr_ptr, and wr_ptr increments.
- Read is accepted when read_i && count>0. rd_ptr increments. read_i while empty is ignored and returns no credit. There is no fall-through: a flit written this cycle is not readable this cycle.
- Simultaneous write and read: both are accepted; count is unchanged. This includes the full case.
- Write when full without a read: the flit is dropped, count is unchanged, and overflow_o is set and held until reset.
- Route on head flit: dest_x = flit[FLIT_W-1:FLIT_W-4], dest_y = flit[FLIT_W-5:FLIT_W-8].
  - dest_x>MY_X → EAST
  - dest_x<MY_X → WEST
  - otherwise, dest_y>MY_Y → NORTH
  - otherwise, dest_y<MY_Y → SOUTH
  - otherwise → LOCAL
- Port codes: NORTH=0, SOUTH=1, EAST=2, WEST=3, LOCAL=4, NONE=7.
- Comparisons are unsigned.

## Timing
- Reset values: count_o=0, credit_en_o=0, overflow_o=0, req_port_addr_o=PORT_NONE, pointers=0. flit_o is don't-care.
- Write at edge N: flit_o and req_port_addr_o reflect that flit after edge N, if it is the head.
- Read accepted at edge N: credit_en_o is high for exactly the cycle after edge N (registered).
- Back-to-back reads produce back-to-back credit pulses, one per flit. No pulses are merged or dropped.
- flit_o, req_port_addr_o and count_o depend only on registered state. There is no combinational path from inputs to outputs.
- Reset mid-operation: contents are discarded and no credits are returned for discarded flits. Upstream flow control shares rst_n and resets to DEPTH credits.

## Structure
- Shared package `noc_pkg` holds:
  - `port_e` enum (3-bit codes above, PORT_NONE=7).
  - Destination field offsets.
  - Coordinate width constant (4).
- Sub-module `noc_xy_route` is purely combinational: inputs are dest_x, dest_y, MY_X and MY_Y; output is port_e. It is reused by the local-injection path.
- Storage is a register array. No SRAM macro.

## Test plan
- Reset then idle → count_o=0, req_port_addr_o=7, credit_en_o=0, overflow_o=0.
- MY_X=1, MY_Y=1; write flits with dest (2,1), (0,1), (1,3), (1,0), (1,1), then read each → req_port_addr_o sequence is 2, 3, 0, 1, 4. Each read is followed next cycle by a single credit_en_o pulse.
- DEPTH=4: write 4 flits → count_o=4. 5th write without read → dropped, overflow_o=1, count_o=4, head unchanged.
- Full, with write and read in the same cycle → count_o stays 4, one credit pulse, new flit read out in FIFO order after the 3 older ones.
- Write 10 flits interleaved with reads so pointers wrap twice → data out matches data in, in order. Total credit pulses = 10.
- 3 flits stored, assert rst_n low mid-burst → all outputs return to reset values asynchronously. No credit pulse is emitted.
